// File: rtl/cmos_capture_pkg.sv
// cmos_capture_pkg
//   Shared definitions for the CMOS camera capture block: capture FSM states,
//   default frame geometry and the widths of the pixel coordinate/address
//   outputs.
package cmos_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int X_W    = 10;  // column, 0..1023
  localparam int Y_W    = 9;   // row, 0..511
  localparam int ADDR_W = 19;  // 640*480 = 307200 < 2^19
  localparam int SKIP_W = 8;   // discarded-frame counter

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    WAIT_VS  = 2'd1,
    SKIP     = 2'd2,
    CAPTURE  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   W-bit 2-flop synchronizer with rise/fall pulses.
//   The edge reference (prev) only advances when en is high, so the pulses
//   describe the change between two consecutive *enabled* samples. With en
//   tied high this is a plain per-cycle edge detector; with en = PCLK rise it
//   gives edges of the camera-sampled signal.
// Ports
//   clk, rst : clock, synchronous active-high reset
//   en       : sample enable for the edge reference
//   d        : asynchronous input
//   q        : synchronized copy (2 cycles latency)
//   rise     : q went 0->1 since last enabled sample (valid while en)
//   fall     : q went 1->0 since last enabled sample (valid while en)
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      q    <= meta;
      if (en) prev <= q;
    end
  end

  assign rise = {W{en}} &  q & ~prev;
  assign fall = {W{en}} & ~q &  prev;

endmodule

// File: rtl/cmos_capture.sv
// cmos_capture
//   Captures RGB565 pixels from an 8-bit parallel CMOS camera interface.
//   Camera signals (PCLK included) are oversampled in the system clock
//   domain; each PCLK rising edge of the synchronized copy is one camera
//   sample. After configuration completes, SKIP_FRAMES whole frames are
//   discarded, then every frame is captured with pixel strobes, coordinates
//   and a linear frame-buffer address.
// Ports
//   iCLK, iRST     : system clock (>= 4x PCLK), synchronous active-high reset
//   iCFG_DONE      : camera configured (level); low forces WAIT_CFG
//   iPCLK/iVSYNC/iHREF/iDATA : raw camera bus
//   oPIX, oPIX_VALID, oX, oY, oADDR : pixel and its position, 1-cycle strobe
//   oFRAME_START/oFRAME_DONE : 1-cycle pulses around each captured frame
//   oLINE_ERR      : sticky odd-byte-count line flag
//   oFRAME_CNT     : captured frames, wrapping
module cmos_capture
  import cmos_capture_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCFG_DONE,
  input  logic              iPCLK,
  input  logic              iVSYNC,
  input  logic              iHREF,
  input  logic [7:0]        iDATA,
  output logic [15:0]       oPIX,
  output logic              oPIX_VALID,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic [ADDR_W-1:0] oADDR,
  output logic              oFRAME_START,
  output logic              oFRAME_DONE,
  output logic              oLINE_ERR,
  output logic [7:0]        oFRAME_CNT
);

  localparam logic [X_W-1:0]    X_LIM     = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_FRAMES);

  // ---------------------------------------------------------------- sync
  logic       pclk_rise;
  logic       unused_pclk_q, unused_pclk_fall, unused_href_rise;
  logic [1:0] ctl_lvl, ctl_rise, ctl_fall;  // {vsync, href}
  logic [7:0] data_meta, data_s;

  sync_edge #(.W(1)) u_pclk_sync (
    .clk (iCLK), .rst (iRST), .en (1'b1), .d (iPCLK),
    .q (unused_pclk_q), .rise (pclk_rise), .fall (unused_pclk_fall)
  );

  sync_edge #(.W(2)) u_ctl_sync (
    .clk (iCLK), .rst (iRST), .en (pclk_rise), .d ({iVSYNC, iHREF}),
    .q (ctl_lvl), .rise (ctl_rise), .fall (ctl_fall)
  );

  // Same 2-flop depth as the control path so data lines up with pclk_rise.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_meta <= '0;
      data_s    <= '0;
    end else begin
      data_meta <= iDATA;
      data_s    <= data_meta;
    end
  end

  logic vs_rise, vs_fall, href_fall, byte_smp;
  assign vs_rise          = ctl_rise[1];
  assign vs_fall          = ctl_fall[1];
  assign href_fall        = ctl_fall[0];
  assign unused_href_rise = ctl_rise[0];
  // a byte is taken only inside an active line of an active frame
  assign byte_smp         = pclk_rise & ctl_lvl[0] & ~ctl_lvl[1];

  // ----------------------------------------------------------------- fsm
  cap_state_t        state;
  logic [SKIP_W-1:0] skip_cnt;
  logic              have_hi;
  logic [7:0]        hi_byte;
  logic [X_W-1:0]    x_cnt;      // column of the next pixel, saturates at H_ACTIVE
  logic [Y_W-1:0]    y_cnt;      // current row, saturates at V_ACTIVE
  logic [ADDR_W-1:0] line_base;  // address of column 0 of the current row
  logic [ADDR_W-1:0] addr_cnt;   // address of the next pixel

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= WAIT_CFG;
      skip_cnt     <= '0;
      have_hi      <= 1'b0;
      hi_byte      <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      line_base    <= '0;
      addr_cnt     <= '0;
      oPIX         <= '0;
      oPIX_VALID   <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oADDR        <= '0;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oLINE_ERR    <= 1'b0;
      oFRAME_CNT   <= '0;
    end else begin
      oPIX_VALID   <= 1'b0;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      if (!iCFG_DONE) begin
        // camera being (re)configured: drop everything in flight
        state     <= WAIT_CFG;
        have_hi   <= 1'b0;
        x_cnt     <= '0;
        y_cnt     <= '0;
        line_base <= '0;
        addr_cnt  <= '0;
      end else begin
        unique case (state)
          WAIT_CFG: begin
            state    <= WAIT_VS;
            skip_cnt <= SKIP_LOAD;
          end
          WAIT_VS: begin
            if (vs_fall) begin
              if (skip_cnt == '0) begin
                state        <= CAPTURE;
                oFRAME_START <= 1'b1;
              end else begin
                state <= SKIP;
              end
            end
          end
          SKIP: begin
            if (vs_rise) begin
              skip_cnt <= skip_cnt - SKIP_W'(1);
              state    <= WAIT_VS;
            end
          end
          CAPTURE: begin
            if (vs_rise) begin
              // frame end wins over any line/byte activity in the same sample
              oFRAME_DONE <= 1'b1;
              oFRAME_CNT  <= oFRAME_CNT + 8'd1;
              have_hi     <= 1'b0;
              x_cnt       <= '0;
              y_cnt       <= '0;
              line_base   <= '0;
              addr_cnt    <= '0;
              skip_cnt    <= '0;
              state       <= WAIT_VS;
            end else if (href_fall) begin
              if (have_hi) oLINE_ERR <= 1'b1;
              have_hi <= 1'b0;
              x_cnt   <= '0;
              if (y_cnt < Y_LIM) begin
                y_cnt     <= y_cnt + Y_W'(1);
                line_base <= line_base + LINE_STEP;
                // jump to the next row even when this one was short
                addr_cnt  <= line_base + LINE_STEP;
              end
            end else if (byte_smp) begin
              if (!have_hi) begin
                hi_byte <= data_s;
                have_hi <= 1'b1;
              end else begin
                have_hi <= 1'b0;
                if (x_cnt < X_LIM && y_cnt < Y_LIM) begin
                  oPIX       <= {hi_byte, data_s};
                  oPIX_VALID <= 1'b1;
                  oX         <= x_cnt;
                  oY         <= y_cnt;
                  oADDR      <= addr_cnt;
                  x_cnt      <= x_cnt + X_W'(1);
                  addr_cnt   <= addr_cnt + ADDR_W'(1);
                end
              end
            end
          end
          default: state <= WAIT_CFG;
        endcase
      end
    end
  end

endmodule
